// File: rtl/bitfusion_seq_ctrl.sv
// Tile sequencer for the BitFusion systolic array: one job at a time, skewed
// input/weight read enables, column accumulator clear, pipeline drain, OBUF valid.
// Latency: start sample to done = 1 + (k_len + 2*(ARRAY_SIZE-1)) + (ARRAY_SIZE*FU_LAT + 2) cycles,
// or 1 cycle (CLEAR then DONE) when k_len = 0.
// Backpressure: none; start is only accepted in IDLE and is dropped otherwise.
// Ports: clk/nRST; job request start + k_len + cfg bitwidths; abort cancels;
// outputs are latched bitwidths, per-row/per-PE read enables, acc_clear,
// busy/done status and obuf_valid.
module bitfusion_seq_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_W        = 8,
  parameter int FU_LAT     = 1
) (
  input  logic                             clk,
  input  logic                             nRST,
  input  logic                             start,
  input  logic                             abort,
  input  logic [K_W-1:0]                   k_len,
  input  logic [2:0]                       cfg_input_bitwidth,
  input  logic [2:0]                       cfg_weight_bitwidth,
  output logic [2:0]                       input_bitwidth,
  output logic [2:0]                       weight_bitwidth,
  output logic [ARRAY_SIZE-1:0]            input_rd_en,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] weight_rd_en,
  output logic [ARRAY_SIZE-1:0]            acc_clear,
  output logic                             busy,
  output logic                             done,
  output logic                             obuf_valid
);

  // Counter covers k_len_max + 2*(ARRAY_SIZE-1) and the drain length with headroom.
  localparam int TW = K_W + $clog2(2 * ARRAY_SIZE) + 1;
  localparam logic [TW-1:0] SKEW       = TW'(2 * (ARRAY_SIZE - 1));
  localparam logic [TW-1:0] DRAIN_LAST = TW'(ARRAY_SIZE * FU_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [K_W-1:0] klen_q, klen_d;
  logic [2:0]     ibw_q, ibw_d;
  logic [2:0]     wbw_q, wbw_d;
  logic           obuf_q, obuf_d;

  logic [TW-1:0]  klen_ext;
  logic [TW-1:0]  run_last;

  assign klen_ext = {{(TW-K_W){1'b0}}, klen_q};
  // Only evaluated in RUN, where klen_q >= 1, so the subtraction cannot underflow.
  assign run_last = klen_ext + SKEW - TW'(1);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      klen_q  <= '0;
      ibw_q   <= '0;
      wbw_q   <= '0;
      obuf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      klen_q  <= klen_d;
      ibw_q   <= ibw_d;
      wbw_q   <= wbw_d;
      obuf_q  <= obuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    klen_d  = klen_q;
    ibw_d   = ibw_q;
    wbw_d   = wbw_q;
    obuf_d  = obuf_q;

    unique case (state_q)
      S_IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          state_d = S_CLEAR;
          t_d     = '0;
          klen_d  = k_len;
          ibw_d   = cfg_input_bitwidth;
          wbw_d   = cfg_weight_bitwidth;
          obuf_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        t_d = '0;
        if (klen_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
          obuf_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (t_q == run_last) begin
          state_d = S_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          state_d = S_DONE;
          t_d     = '0;
          obuf_d  = 1'b1;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      t_d     = '0;
      obuf_d  = 1'b0;
    end
  end

  // Output decode: registered state and counter only.
  always_comb begin
    input_rd_en  = '0;
    weight_rd_en = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        input_rd_en[i] = (t_q >= TW'(i)) && (t_q < TW'(i) + klen_ext);
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          // each PE sees its row skew plus its column skew
          weight_rd_en[i*ARRAY_SIZE+j] = (t_q >= TW'(i + j)) &&
                                         (t_q < TW'(i + j) + klen_ext);
        end
      end
    end
  end

  assign acc_clear       = {ARRAY_SIZE{state_q == S_CLEAR}};
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign obuf_valid      = obuf_q;
  assign input_bitwidth  = ibw_q;
  assign weight_bitwidth = wbw_q;

endmodule
